// File: rtl/id_stage_if.sv
// IF->ID->EX bundle for the decode stage: upstream handshake, RF read addresses
// and the registered decoded instruction.
interface id_stage_if;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] ins_i;
  logic [31:0] ins_addr_i;
  logic [4:0]  reg1_rd_addr_o;
  logic [4:0]  reg2_rd_addr_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] ins_addr_o;
  logic [4:0]  reg_wr_addr_o;
  logic        reg_we_o;
  logic [31:0] imm_o;
  logic [3:0]  cls_o;
  logic [2:0]  funct3_o;
  logic        alt_o;
  logic        illegal_o;

  modport slave (
    input  flush_i, in_valid_i, ins_i, ins_addr_i, out_ready_i,
    output in_ready_o, reg1_rd_addr_o, reg2_rd_addr_o, out_valid_o, ins_addr_o,
           reg_wr_addr_o, reg_we_o, imm_o, cls_o, funct3_o, alt_o, illegal_o
  );
  modport master (
    output flush_i, in_valid_i, ins_i, ins_addr_i, out_ready_i,
    input  in_ready_o, reg1_rd_addr_o, reg2_rd_addr_o, out_valid_o, ins_addr_o,
           reg_wr_addr_o, reg_we_o, imm_o, cls_o, funct3_o, alt_o, illegal_o
  );
endinterface

// File: rtl/id_stage.sv
// Registered RV32I/E decode stage with valid/ready output register, flush,
// illegal-instruction flagging and a load-use interlock.
module id_stage #(
  parameter bit          RV32E    = 1'b0,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  id_stage_if.slave bus
);
  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111,
                         OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011;
  localparam logic [3:0] C_OP = 4'd0, C_OPIMM = 4'd1, C_LUI = 4'd2, C_AUIPC = 4'd3, C_JAL = 4'd4,
                         C_JALR = 4'd5, C_BRANCH = 4'd6, C_LOAD = 4'd7, C_STORE = 4'd8,
                         C_MULDIV = 4'd9, C_ILL = 4'd15;
  localparam logic [2:0] LAT = 3'(LOAD_LAT);

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic        ill;
  } dec_t;

  logic [31:0] ins;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  assign ins = bus.ins_i;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];
  assign rd  = ins[11:7];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];

  logic [31:0] imm_i, imm_sh, imm_s, imm_b, imm_u, imm_j;
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_sh = {27'd0, ins[24:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'd0};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  logic        legal, use_rd, use1, use2;
  logic [3:0]  cls_raw;
  logic [31:0] imm_raw;

  always_comb begin
    legal   = 1'b1;
    use_rd  = 1'b0;
    use1    = 1'b0;
    use2    = 1'b0;
    cls_raw = C_ILL;
    imm_raw = '0;
    case (opc)
      OPC_OP: begin
        use_rd = 1'b1; use1 = 1'b1; use2 = 1'b1;
        cls_raw = C_OP;
        if (f7 == 7'b0000001 && ENABLE_M) cls_raw = C_MULDIV;
        else if (f7 == 7'b0100000)        legal = (f3 == 3'b000) || (f3 == 3'b101);
        else if (f7 != 7'b0000000)        legal = 1'b0;
      end
      OPC_OPIMM: begin
        use_rd = 1'b1; use1 = 1'b1;
        cls_raw = C_OPIMM;
        imm_raw = imm_i;
        if (f3 == 3'b001) begin
          imm_raw = imm_sh;
          legal   = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          imm_raw = imm_sh;
          legal   = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        end
      end
      OPC_LUI:    begin use_rd = 1'b1; cls_raw = C_LUI;   imm_raw = imm_u; end
      OPC_AUIPC:  begin use_rd = 1'b1; cls_raw = C_AUIPC; imm_raw = imm_u; end
      OPC_JAL:    begin use_rd = 1'b1; cls_raw = C_JAL;   imm_raw = imm_j; end
      OPC_JALR: begin
        use_rd = 1'b1; use1 = 1'b1; cls_raw = C_JALR; imm_raw = imm_i;
        legal  = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        use1 = 1'b1; use2 = 1'b1; cls_raw = C_BRANCH; imm_raw = imm_b;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use1 = 1'b1; cls_raw = C_LOAD; imm_raw = imm_i;
        legal  = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OPC_STORE: begin
        use1 = 1'b1; use2 = 1'b1; cls_raw = C_STORE; imm_raw = imm_s;
        legal = (f3[2] == 1'b0) && (f3 != 3'b011);
      end
      default: legal = 1'b0;
    endcase
    if (RV32E && ((use_rd && rd[4]) || (use1 && rs1[4]) || (use2 && rs2[4]))) legal = 1'b0;
  end

  dec_t       dec, out_q, out_d;
  logic       valid_q, valid_d;
  logic [2:0] lcnt_q, lcnt_d;
  logic [4:0] lrd_q, lrd_d;
  logic [4:0] r1, r2;
  logic       hazard, in_ready, accept, handoff;

  // Unused operand fields read as x0 so they can never match the pending load rd.
  assign r1 = (legal && use1) ? rs1 : 5'd0;
  assign r2 = (legal && use2) ? rs2 : 5'd0;

  always_comb begin
    dec.addr = bus.ins_addr_i;
    dec.we   = legal && use_rd && (rd != 5'd0);
    dec.wa   = dec.we ? rd : 5'd0;
    dec.imm  = legal ? imm_raw : 32'd0;
    dec.cls  = legal ? cls_raw : C_ILL;
    dec.f3   = f3;
    dec.alt  = legal && ins[30] && ((cls_raw == C_OP) || (opc == OPC_OPIMM && f3 == 3'b101));
    dec.ill  = !legal;
  end

  assign hazard   = (lcnt_q != 3'd0) && ((r1 == lrd_q) || (r2 == lrd_q));
  assign in_ready = (!valid_q || bus.out_ready_i) && !hazard && !bus.flush_i;
  assign accept   = bus.in_valid_i && in_ready;
  assign handoff  = valid_q && bus.out_ready_i && !bus.flush_i;

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    lcnt_d  = lcnt_q;
    lrd_d   = lrd_q;
    if (bus.flush_i) valid_d = 1'b0;
    else if (accept) begin
      valid_d = 1'b1;
      out_d   = dec;
    end else if (handoff) valid_d = 1'b0;
    // A load with a real destination arms the interlock as it leaves for EX.
    if (handoff && out_q.cls == C_LOAD && out_q.we) begin
      lcnt_d = LAT;
      lrd_d  = out_q.wa;
    end else if (lcnt_q != 3'd0) lcnt_d = lcnt_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      lcnt_q  <= '0;
      lrd_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      lcnt_q  <= lcnt_d;
      lrd_q   <= lrd_d;
    end
  end

  assign bus.in_ready_o     = in_ready;
  assign bus.reg1_rd_addr_o = r1;
  assign bus.reg2_rd_addr_o = r2;
  assign bus.out_valid_o    = valid_q;
  assign bus.ins_addr_o     = out_q.addr;
  assign bus.reg_wr_addr_o  = out_q.wa;
  assign bus.reg_we_o       = out_q.we;
  assign bus.imm_o          = out_q.imm;
  assign bus.cls_o          = out_q.cls;
  assign bus.funct3_o       = out_q.f3;
  assign bus.alt_o          = out_q.alt;
  assign bus.illegal_o      = out_q.ill;
endmodule

// File: tb/tb_id_stage.sv
// Two decode stages (RV32I+M, LOAD_LAT=1 and RV32E no-M, LOAD_LAT=3) share one random
// stimulus stream; each has its own reference model and scoreboard.
module tb_id_stage;
  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic        ill;
  } exp_t;
  typedef struct packed {
    exp_t       e;
    logic [4:0] r1;
    logic [4:0] r2;
  } dec_t;

  logic clk, rst_n;
  logic t_vin, t_ordy, t_fl;
  logic [31:0] t_ins, t_addr;
  int total = 0, bad = 0;

  id_stage_if bus0();
  id_stage_if bus1();
  assign bus0.flush_i = t_fl;   assign bus1.flush_i = t_fl;
  assign bus0.in_valid_i = t_vin; assign bus1.in_valid_i = t_vin;
  assign bus0.ins_i = t_ins;    assign bus1.ins_i = t_ins;
  assign bus0.ins_addr_i = t_addr; assign bus1.ins_addr_i = t_addr;
  assign bus0.out_ready_i = t_ordy; assign bus1.out_ready_i = t_ordy;

  id_stage #(.RV32E(1'b0), .ENABLE_M(1'b1), .LOAD_LAT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  id_stage #(.RV32E(1'b1), .ENABLE_M(1'b0), .LOAD_LAT(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  exp_t obs0, obs1;
  assign obs0 = {bus0.ins_addr_o, bus0.reg_wr_addr_o, bus0.reg_we_o, bus0.imm_o, bus0.cls_o,
                 bus0.funct3_o, bus0.alt_o, bus0.illegal_o};
  assign obs1 = {bus1.ins_addr_o, bus1.reg_wr_addr_o, bus1.reg_we_o, bus1.imm_o, bus1.cls_o,
                 bus1.funct3_o, bus1.alt_o, bus1.illegal_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [78:0] act, input logic [78:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Sign-extend the low 'bits' bits of v.
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    int t;
    t = int'(v << (32 - bits));
    return 32'(t >>> (32 - bits));
  endfunction

  // Reference decoder; d=0 is the RV32I+M stage, d=1 the RV32E stage without M.
  function automatic dec_t mdec(input logic [31:0] w, input logic [31:0] a, input int d);
    dec_t r;
    logic ok, urd, u1, u2;
    logic [3:0] c;
    logic [31:0] im;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12]; f7 = w[31:25];
    ok = 1; urd = 0; u1 = 0; u2 = 0; c = 4'd15; im = 0;
    case (w[6:0])
      7'h33: begin
        urd = 1; u1 = 1; u2 = 1; c = 4'd0;
        if (f7 == 7'h01) begin c = 4'd9; ok = (d == 0); end
        else if (f7 == 7'h20) ok = (f3 == 3'd0 || f3 == 3'd5);
        else ok = (f7 == 7'h00);
      end
      7'h13: begin
        urd = 1; u1 = 1; c = 4'd1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          im = {27'd0, w[24:20]};
          ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        end else im = sx(w >> 20, 12);
      end
      7'h37, 7'h17: begin urd = 1; c = (w[6:0] == 7'h37) ? 4'd2 : 4'd3; im = w & 32'hFFFFF000; end
      7'h6f: begin urd = 1; c = 4'd4; im = sx({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21); end
      7'h67: begin urd = 1; u1 = 1; c = 4'd5; ok = (f3 == 3'd0); im = sx(w >> 20, 12); end
      7'h63: begin
        u1 = 1; u2 = 1; c = 4'd6; ok = !(f3 == 3'd2 || f3 == 3'd3);
        im = sx({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
      end
      7'h03: begin urd = 1; u1 = 1; c = 4'd7; ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); im = sx(w >> 20, 12); end
      7'h23: begin u1 = 1; u2 = 1; c = 4'd8; ok = (f3 <= 3'd2); im = sx({20'd0, w[31:25], w[11:7]}, 12); end
      default: ok = 0;
    endcase
    if (d == 1 && ((urd && w[11:7] > 15) || (u1 && w[19:15] > 15) || (u2 && w[24:20] > 15))) ok = 0;
    r.e.addr = a;
    r.e.ill  = !ok;
    r.e.cls  = ok ? c : 4'd15;
    r.e.imm  = ok ? im : 32'd0;
    r.e.we   = ok && urd && (w[11:7] != 0);
    r.e.wa   = r.e.we ? w[11:7] : 5'd0;
    r.e.f3   = f3;
    r.e.alt  = ok && w[30] && (c == 4'd0 || (c == 4'd1 && f3 == 3'd5));
    r.r1     = (ok && u1) ? w[19:15] : 5'd0;
    r.r2     = (ok && u2) ? w[24:20] : 5'd0;
    return r;
  endfunction

  // Reference stage state: held flag, held instruction, pending-load rd and cycles left.
  logic       mv [2];
  exp_t       mh [2];
  logic [4:0] ml [2];
  int         mc [2];
  exp_t       q0[$], q1[$];

  function automatic logic mrdy(input int d);
    dec_t x;
    x = mdec(t_ins, t_addr, d);
    return (!mv[d] || t_ordy) && !t_fl && !(mc[d] != 0 && (x.r1 == ml[d] || x.r2 == ml[d]));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mv[d] <= 1'b0; mh[d] <= '0; ml[d] <= '0; mc[d] <= 0;
      end
      q0.delete(); q1.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        dec_t x;
        logic hand;
        x = mdec(t_ins, t_addr, d);
        hand = mv[d] && t_ordy && !t_fl;
        if (hand && mh[d].cls == 4'd7 && mh[d].we) begin
          ml[d] <= mh[d].wa;
          mc[d] <= (d == 0) ? 1 : 3;
        end else if (mc[d] != 0) mc[d] <= mc[d] - 1;
        if (t_fl) mv[d] <= 1'b0;
        else if (t_vin && mrdy(d)) begin
          mv[d] <= 1'b1;
          mh[d] <= x.e;
          if (d == 0) q0.push_back(x.e); else q1.push_back(x.e);
        end else if (hand) mv[d] <= 1'b0;
      end
    end
  end

  // Monitor: compare whatever each stage presents against its scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        dec_t x;
        exp_t o, f;
        int n;
        logic ov, ir;
        logic [4:0] a1, a2;
        x  = mdec(t_ins, t_addr, d);
        o  = (d == 0) ? obs0 : obs1;
        ov = (d == 0) ? bus0.out_valid_o : bus1.out_valid_o;
        ir = (d == 0) ? bus0.in_ready_o : bus1.in_ready_o;
        a1 = (d == 0) ? bus0.reg1_rd_addr_o : bus1.reg1_rd_addr_o;
        a2 = (d == 0) ? bus0.reg2_rd_addr_o : bus1.reg2_rd_addr_o;
        chk($sformatf("in_ready%0d", d), 79'(ir), 79'(mrdy(d)));
        chk($sformatf("out_valid%0d", d), 79'(ov), 79'(mv[d]));
        chk($sformatf("rf_addr%0d", d), 79'({a1, a2}), 79'({x.r1, x.r2}));
        if (ov) begin
          n = (d == 0) ? q0.size() : q1.size();
          if (n == 0) begin
            total++; bad++;
            $display("FAIL out%0d act=%h exp=<none queued>", d, o);
          end else begin
            f = (d == 0) ? q0[0] : q1[0];
            chk($sformatf("out%0d", d), o, f);
            if (t_ordy || t_fl) begin
              if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] a,
                       input logic r, input logic f);
    t_vin = v; t_ins = w; t_addr = a; t_ordy = r; t_fl = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [6:0] opcs [9];
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23};
    if ($urandom_range(0, 9) == 0) return $urandom;
    rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    rs1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    rs2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, rs2, rs1, 3'($urandom_range(0, 7)), rd, opcs[$urandom_range(0, 8)]};
  endfunction

  initial begin
    logic [31:0] addr;
    rst_n = 1'b0;
    drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    #12;
    chk("rst_valid", 79'(bus0.out_valid_o), 79'(0));
    chk("rst_regs", obs0, 79'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 79'(bus0.in_ready_o), 79'(1));
    tick();
    chk("addi", 79'({bus0.out_valid_o, bus0.cls_o, bus0.reg_wr_addr_o, bus0.reg_we_o, bus0.imm_o, bus0.ins_addr_o}),
        79'({1'b1, 4'd1, 5'd1, 1'b1, 32'd5, 32'h100}));
    drive(1'b1, 32'hFFF0B113, 32'h104, 1'b1, 1'b0); tick();
    chk("sltiu_imm", 79'(bus0.imm_o), 79'(32'hFFFFFFFF));
    drive(1'b1, 32'hFE41FEE3, 32'h108, 1'b1, 1'b0); #1;
    chk("bgeu_rf", 79'({bus0.reg1_rd_addr_o, bus0.reg2_rd_addr_o}), 79'({5'd3, 5'd4}));
    tick();
    chk("bgeu_out", 79'({bus0.imm_o, bus0.reg_we_o}), 79'({32'hFFFFFFFC, 1'b0}));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rnd_ins(), 32'h10C + 32'(i), 1'b0, 1'b0); #1;
      chk("stall_ready", 79'(bus0.in_ready_o), 79'(0));
      tick();
      chk("stall_hold", 79'({bus0.out_valid_o, bus0.imm_o, bus0.ins_addr_o}), 79'({1'b1, 32'hFFFFFFFC, 32'h108}));
    end
    drive(1'b1, 32'h00500093, 32'h200, 1'b1, 1'b0); #1;
    chk("release_ready", 79'(bus0.in_ready_o), 79'(1));
    tick();
    chk("release_next", 79'(bus0.ins_addr_o), 79'(32'h200));
    // Load-use: dependent add stalls exactly one cycle on the LOAD_LAT=1 stage.
    drive(1'b1, 32'h0000A283, 32'h300, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h00528333, 32'h304, 1'b1, 1'b0); #1;
    chk("luse_stall", 79'(bus0.in_ready_o), 79'(0));
    tick();
    chk("luse_release", 79'(bus0.in_ready_o), 79'(1));
    tick();
    chk("luse_accept", 79'(bus0.ins_addr_o), 79'(32'h304));
    drive(1'b1, 32'h0000A283, 32'h308, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h00738333, 32'h30C, 1'b1, 1'b0); #1;
    chk("luse_indep", 79'(bus0.in_ready_o), 79'(1));
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (4) tick();
    // Flush while the held instruction is stalled by EX.
    drive(1'b1, 32'h00500093, 32'h400, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h00100113, 32'h404, 1'b0, 1'b1); #1;
    chk("flush_ready", 79'(bus0.in_ready_o), 79'(0));
    tick();
    chk("flush_kill", 79'(bus0.out_valid_o), 79'(0));
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    chk("flush_noacc", 79'(bus0.out_valid_o), 79'(0));
    drive(1'b1, 32'h023100B3, 32'h500, 1'b1, 1'b0); tick();
    chk("mul_m", 79'({bus0.cls_o, bus0.illegal_o}), 79'({4'd9, 1'b0}));
    chk("mul_nom", 79'({bus1.cls_o, bus1.illegal_o}), 79'({4'd15, 1'b1}));
    drive(1'b1, 32'h00100893, 32'h504, 1'b1, 1'b0); tick();
    chk("x17_e", 79'({bus1.illegal_o, bus1.reg_we_o, bus1.imm_o}), 79'({1'b1, 1'b0, 32'd0}));
    chk("x17_i", 79'({bus0.illegal_o, bus0.reg_wr_addr_o}), 79'({1'b0, 5'd17}));
    addr = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rnd_ins(), addr, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
      addr += 4;
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (8) tick();
    chk("drain", 79'({q0.size(), q1.size()}), 79'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Registered, handshaked RV32I instruction decode stage, parametrised for RV32E register count, optional M-extension decode and a load-use interlock.
- Sits between IF and EX and replaces the combinational decoder.
- Drives RF read addresses combinationally.
- Holds one decoded instruction in an output register with valid/ready flow control, flush and illegal-instruction flagging.

Parameters:
- RV32E, 0, 1 = only x0..x15 legal; any used register field above 15 makes the instruction illegal.
- ENABLE_M, 0, 1 = OP opcode with funct7=0000001 decodes as legal MUL/DIV class; 0 = illegal.
- LOAD_LAT, 1, cycles (1..7) a dependent instruction is held after a load with rd!=0 leaves this stage; 0 disables the interlock.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  kill held instruction (branch/jump redirect)
- in_valid_i  in  1  IF presents instruction
- in_ready_o  out  1  stage accepts this cycle
- ins_i  in  32  instruction word
- ins_addr_i  in  32  instruction address
- reg1_rd_addr_o  out  5  rs1 to RF, combinational from ins_i; 0 if unused
- reg2_rd_addr_o  out  5  rs2 to RF, combinational; 0 if unused
- out_valid_o  out  1  decoded instruction held
- out_ready_i  in  1  EX accepts
- ins_addr_o  out  32  registered address
- reg_wr_addr_o  out  5  rd; 0 when no write
- reg_we_o  out  1  writes rd (rd!=0)
- imm_o  out  32  decoded immediate
- cls_o  out  4  class: 0 OP,1 OP-IMM,2 LUI,3 AUIPC,4 JAL,5 JALR,6 BRANCH,7 LOAD,8 STORE,9 MULDIV,15 illegal
- funct3_o  out  3  raw funct3
- alt_o  out  1  ins[30] for SUB/SRA/SRAI
- illegal_o  out  1  illegal instruction

Behaviour:
- Reset (async, rst_n=0): out_valid_o=0, all registered outputs 0, interlock counter 0, captured rd 0.
- Handshake: in_ready_o = (!out_valid_o | out_ready_i) & !hazard. Accept = in_valid_i & in_ready_o. On accept the output register loads next cycle. Latency is 1 cycle; full throughput of 1 per cycle when out_ready_i=1.
- If out_valid_o=1 and out_ready_i=0: hold all outputs stable. in_valid_i/ins_i may change; nothing is captured.
- flush_i (highest priority): next cycle out_valid_o=0 and no accept that cycle; in_ready_o forced 0 while flush_i=1. The interlock counter is unaffected (the load is already in EX).
- Immediates:
  - I-type: sign-extended ins[31:20], including SLTIU/XORI/ORI/ANDI.
  - Shifts: zero-extended ins[24:20].
  - S: sign-extended {ins[31:25],ins[11:7]}.
  - B: sign-extended {ins[31],ins[7],ins[30:25],ins[11:8],0}.
  - U: {ins[31:12],12'b0}.
  - J: sign-extended {ins[31],ins[19:12],ins[20],ins[30:21],0}.
  - R-type: 0.
- Operand order is never swapped: BGEU presents rs1 on port 1 and rs2 on port 2.
- Legality: opcode must be one of the nine base opcodes and ins[1:0]=11.
  - JALR requires funct3=000.
  - BRANCH excludes funct3 010/011.
  - LOAD requires funct3 in {000,001,010,100,101}; STORE in {000,001,010}.
  - SLLI requires funct7=0; SRLI/SRAI require funct7 in {0000000,0100000}.
  - OP requires funct7=0000000, or 0100000 only with funct3 000/101, or 0000001 when ENABLE_M=1.
  - RV32E register rule per Parameters.
- Illegal instruction: still passes through the handshake with illegal_o=1, cls_o=15, reg_we_o=0, reg_wr_addr_o=0, imm_o=0, RF addresses 0.
- Interlock (LOAD_LAT>0):
  - When a LOAD with rd!=0 hands off (out_valid_o & out_ready_i & cls=LOAD), capture rd and set counter=LOAD_LAT.
  - The counter decrements each cycle while nonzero.
  - hazard = counter!=0 & (used rs1==captured rd | used rs2==captured rd).
  - Back-to-back loads reload the capture on each handoff.

Test Plan:
- Reset with in_valid_i=1 -> out_valid_o=0, in_ready_o=1 after release; first accepted ins 0x00500093 (addi x1,x0,5) at addr 0x100 -> next cycle cls=1, reg_wr_addr_o=1, reg_we_o=1, imm_o=5, ins_addr_o=0x100.
- sltiu x2,x1,-1 (0xFFF0B113) -> imm_o=0xFFFFFFFF. bgeu x3,x4,-4 (0xFE41FEE3) -> reg1_rd_addr_o=3, reg2_rd_addr_o=4, imm_o=0xFFFFFFFC, reg_we_o=0.
- out_ready_i=0 for 3 cycles with new ins_i each cycle -> outputs frozen, in_ready_o=0; ready rises -> one handoff, next instruction accepted the same cycle.
- LOAD_LAT=1: lw x5,0(x1) hands off, then add x6,x5,x5 offered -> in_ready_o=0 for exactly 1 cycle. add x6,x7,x7 offered instead -> no stall.
- flush_i asserted while out_valid_o=1 and out_ready_i=0 -> out_valid_o=0 next cycle, the instruction offered that cycle is not accepted.
- mul x1,x2,x3 (0x023100B3) with ENABLE_M=0 -> illegal_o=1, cls=15; with ENABLE_M=1 -> cls=9. RV32E=1 with addi x17,x0,1 -> illegal_o=1.
